// File: rtl/wave_ddr_fetch.sv
// wave_ddr_fetch
// Byte-fetch front end between the wave sample player's DMA byte port and a
// 64-bit DDR port. Two 64-bit line buffers serve byte reads at any 28-bit byte
// address. A miss fetches the containing line. A hit prefetches the next
// sequential line into the other buffer, so sequential playback does not stall.
//
// Optional build feature:
//   WAVE_FETCH_STATS_EN - adds O_MISS_CNT, a saturating count of miss-initiated
//                         DDR request accepts. I_FLUSH clears it.
module wave_ddr_fetch #(
  parameter logic [28:0] BASE_WADDR = 29'h0600_0000,
  parameter logic [7:0]  BURST      = 8'd1
) (
  input  logic        I_CLK,
  input  logic        I_RSTn,
  input  logic        I_FLUSH,
  input  logic [27:0] I_BYTE_ADDR,
  output logic [7:0]  O_BYTE_DATA,
  output logic        O_BYTE_READY,
  input  logic        I_DDR_BUSY,
  output logic        O_DDR_RD,
  output logic [28:0] O_DDR_ADDR,
  output logic [7:0]  O_DDR_BURSTCNT,
  input  logic [63:0] I_DDR_DOUT,
  input  logic        I_DDR_DOUT_READY
`ifdef WAVE_FETCH_STATS_EN
  ,
  output logic [15:0] O_MISS_CNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;

  // Line buffers: valid bits are reset, tag/data are qualified by valid.
  logic [1:0]  line_valid;
  logic [24:0] line_tag  [2];
  logic [63:0] line_data [2];

  logic        last_hit;   // index of the line that hit most recently
  logic        target;     // line being filled by the in-flight fetch
  logic [24:0] ftag;       // tag being fetched
  logic        miss_req;   // in-flight fetch was started by a miss
  logic        drop;       // in-flight fetch was flushed; discard its data

  // Lookup signals
  logic [24:0] cur_tag;
  logic [2:0]  byte_sel;
  logic [24:0] next_tag;
  logic        hit0;
  logic        hit1;
  logic        any_hit;
  logic        hit_idx;
  logic        other_idx;
  logic        miss_tgt;
  logic        other_has_next;
  logic [63:0] sel_line;
  logic [7:0]  sel_byte;
  logic        fill_en;

  assign O_DDR_BURSTCNT = BURST;

  // Tag compare, byte select and next-line check for the current address.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_tag        = I_BYTE_ADDR[27:3];
    byte_sel       = I_BYTE_ADDR[2:0];
    next_tag       = cur_tag + 25'd1;   // wraps 0x1FFFFFF -> 0 naturally
    hit0           = line_valid[0] && (line_tag[0] == cur_tag);
    hit1           = line_valid[1] && (line_tag[1] == cur_tag);
    any_hit        = hit0 || hit1;
    hit_idx        = hit1;
    other_idx      = ~hit_idx;
    miss_tgt       = ~last_hit;
    other_has_next = line_valid[other_idx] && (line_tag[other_idx] == next_tag);
    sel_line       = hit_idx ? line_data[1] : line_data[0];
    sel_byte       = sel_line[{byte_sel, 3'b000} +: 8];
    fill_en        = (state == S_WAIT) && I_DDR_DOUT_READY && !drop && !I_FLUSH;
  end

  // Line tag/data storage, written only when a fetch completes undropped.
  // NOTE: the line storage has no reset; line_valid alone decides whether a
  // line may be used, so clearing the wide data would only cost flops.
  always_ff @(posedge I_CLK) begin
    if (fill_en) begin
      line_tag[target]  <= ftag;
      line_data[target] <= I_DDR_DOUT;
    end
  end

  // Byte output register, valid bits and the fetch state machine.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      O_BYTE_DATA  <= 8'd0;
      O_BYTE_READY <= 1'b0;
      O_DDR_RD     <= 1'b0;
      O_DDR_ADDR   <= 29'd0;
      line_valid   <= 2'b00;
      last_hit     <= 1'b0;
      target       <= 1'b0;
      ftag         <= 25'd0;
      miss_req     <= 1'b0;
      drop         <= 1'b0;
      state        <= S_IDLE;
    end else begin
      // Output stage: one cycle latency, data holds on no hit.
      O_BYTE_READY <= any_hit && !I_FLUSH;
      if (any_hit) begin
        O_BYTE_DATA <= sel_byte;
        last_hit    <= hit_idx;
      end

      case (state)
        S_IDLE: begin
          if (!I_FLUSH) begin
            if (!any_hit) begin
              // Miss: refill the line that was not used most recently.
              target               <= miss_tgt;
              ftag                 <= cur_tag;
              miss_req             <= 1'b1;
              line_valid[miss_tgt] <= 1'b0;
              O_DDR_RD             <= 1'b1;
              O_DDR_ADDR           <= BASE_WADDR + {4'd0, cur_tag};
              state                <= S_REQ;
            end else if (!other_has_next) begin
              // Hit: stage the next sequential line in the other buffer.
              target                <= other_idx;
              ftag                  <= next_tag;
              miss_req              <= 1'b0;
              line_valid[other_idx] <= 1'b0;
              O_DDR_RD              <= 1'b1;
              O_DDR_ADDR            <= BASE_WADDR + {4'd0, next_tag};
              state                 <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // The request cannot be withdrawn; a flush only marks it for discard.
          if (I_FLUSH) begin
            drop <= 1'b1;
          end
          if (!I_DDR_BUSY) begin
            O_DDR_RD <= 1'b0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (I_DDR_DOUT_READY) begin
            if (fill_en) begin
              line_valid[target] <= 1'b1;
            end
            drop  <= 1'b0;
            state <= S_IDLE;
          end else if (I_FLUSH) begin
            drop <= 1'b1;
          end
        end

        default: begin
          O_DDR_RD <= 1'b0;
          drop     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase

      // Flush invalidates both lines, overriding any fill or clear above.
      if (I_FLUSH) begin
        line_valid <= 2'b00;
      end
    end
  end

`ifdef WAVE_FETCH_STATS_EN
  logic [15:0] miss_cnt;

  assign O_MISS_CNT = miss_cnt;

  // Saturating count of accepted miss requests; prefetches are not counted.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      miss_cnt <= 16'd0;
    end else if (I_FLUSH) begin
      miss_cnt <= 16'd0;
    end else if ((state == S_REQ) && !I_DDR_BUSY && miss_req && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wave_ddr_fetch.sv
// Testbench for wave_ddr_fetch: directed address sequences against a DDR
// responder model. Expected DDR requests and expected bytes are queued by the
// stimulus and popped by independent monitor processes.
module tb_wave_ddr_fetch;

  localparam logic [28:0] BASE    = 29'h0600_0000;
  localparam int          DDR_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic [27:0] byte_addr;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        ddr_busy;
  logic        ddr_rd;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;
`ifdef WAVE_FETCH_STATS_EN
  logic [15:0] miss_cnt;
`endif

  wave_ddr_fetch dut (
    .I_CLK            (clk),
    .I_RSTn           (rst_n),
    .I_FLUSH          (flush),
    .I_BYTE_ADDR      (byte_addr),
    .O_BYTE_DATA      (byte_data),
    .O_BYTE_READY     (byte_ready),
    .I_DDR_BUSY       (ddr_busy),
    .O_DDR_RD         (ddr_rd),
    .O_DDR_ADDR       (ddr_addr),
    .O_DDR_BURSTCNT   (ddr_burstcnt),
    .I_DDR_DOUT       (ddr_dout),
    .I_DDR_DOUT_READY (ddr_dout_ready)
`ifdef WAVE_FETCH_STATS_EN
    ,
    .O_MISS_CNT       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [28:0] exp_req[$];
  logic [7:0]  exp_byte[$];
  int          want_cnt = 0;   // byte reads requested by stimulus
  int          got_cnt = 0;    // byte reads served by the monitor
  int          ddr_accepts = 0;
  int          ddr_fills = 0;
  logic [27:0] addr_q = 28'd0; // address the DUT sampled at the last edge

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Memory content: byte at byte offset a.
  function automatic logic [7:0] mem_byte(input logic [27:0] a);
    return (a[7:0] + 8'd1) ^ a[15:8];
  endfunction

  function automatic logic [63:0] ddr_word(input logic [28:0] w);
    logic [28:0] off;
    logic [27:0] ba;
    logic [63:0] r;
    off = w - BASE;
    ba  = {off[24:0], 3'b000};
    r   = 64'd0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mem_byte(ba + 28'(k));
    return r;
  endfunction

  // Track the address the DUT registers at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      addr_q = byte_addr;
    end
  end

  // Byte monitor: every ready byte must match memory; queued reads are popped.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && byte_ready) begin
        check("byte_track", 64'(byte_data), 64'(mem_byte(addr_q)));
        if (got_cnt < want_cnt) begin
          e = exp_byte.pop_front();
          check("byte_read", 64'(byte_data), 64'(e));
          got_cnt++;
        end
      end
    end
  end

  // DDR responder and request monitor: one outstanding read, fixed latency.
  initial begin
    logic [28:0] a;
    ddr_dout_ready = 1'b0;
    ddr_dout       = 64'd0;
    forever begin
      @(negedge clk);
      if (rst_n && ddr_rd && !ddr_busy) begin
        a = ddr_addr;
        ddr_accepts++;
        if (exp_req.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL ddr_req: actual unexpected request 0x%0h required none", a);
        end else begin
          check("ddr_req_addr", 64'(a), 64'(exp_req.pop_front()));
        end
        @(posedge clk);
        repeat (DDR_LAT - 1) @(posedge clk);
        #1;
        ddr_dout       = ddr_word(a);
        ddr_dout_ready = 1'b1;
        ddr_fills++;
        @(posedge clk);
        #1;
        ddr_dout_ready = 1'b0;
      end
    end
  end

  task automatic read_byte(input logic [27:0] a, input logic [7:0] e, input int max_cyc);
    @(posedge clk);
    #1;
    byte_addr = a;
    exp_byte.push_back(e);
    @(posedge clk);
    want_cnt++;
    for (int i = 0; i < max_cyc && got_cnt != want_cnt; i++) @(posedge clk);
    if (got_cnt != want_cnt) timeout_fail("read_byte");
  endtask

  task automatic wait_accepts(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && ddr_accepts < n; i++) @(posedge clk);
    if (ddr_accepts < n) timeout_fail("wait_accepts");
  endtask

  initial begin
    int base_acc;
    int base_fill;
    int drops;
    int cyc;
    flush     = 1'b0;
    ddr_busy  = 1'b0;
    byte_addr = 28'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_data", 64'(byte_data), 64'd0);
    check("rst_rd", 64'(ddr_rd), 64'd0);
    check("rst_ddr_addr", 64'(ddr_addr), 64'd0);
    check("burstcnt", 64'(ddr_burstcnt), 64'd1);
`ifdef WAVE_FETCH_STATS_EN
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif

    // First miss at byte 0, then a hit at byte 5 with only a prefetch issued.
    exp_req.push_back(29'h600_0000);
    exp_req.push_back(29'h600_0001);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_byte(28'h0, 8'h01, 20);
    read_byte(28'h5, 8'h06, 1);
    wait_accepts(2, 30);
    repeat (6) @(posedge clk);
    check("first_fill_accepts", 64'(ddr_accepts), 64'd2);

    // Sequential sweep: READY stays high, prefetches stay one line ahead.
    exp_req.push_back(29'h600_0002);
    exp_req.push_back(29'h600_0003);
    exp_req.push_back(29'h600_0004);
    drops = 0;
    for (int a = 0; a < 32; a++) begin
      @(posedge clk);
      #1;
      byte_addr = 28'(a);
      exp_byte.push_back(mem_byte(28'(a)));
      @(negedge clk);
      if (!byte_ready) drops++;
      @(posedge clk);
      want_cnt++;
      repeat (15) begin
        @(negedge clk);
        if (!byte_ready) drops++;
      end
    end
    repeat (8) @(posedge clk);
    check("sweep_ready_drops", 64'(drops), 64'd0);
    check("sweep_reads_served", 64'(got_cnt), 64'(want_cnt));
    check("sweep_accepts", 64'(ddr_accepts), 64'd5);
`ifdef WAVE_FETCH_STATS_EN
    check("sweep_miss_cnt", 64'(miss_cnt), 64'd1);
`endif

    // DDR busy for 10 clocks during REQ: request held stable, one accept.
    base_acc = ddr_accepts;
    exp_req.push_back(29'h600_0040);
    exp_req.push_back(29'h600_0041);
    @(posedge clk);
    #1;
    ddr_busy  = 1'b1;
    byte_addr = 28'h200;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      check("busy_rd_held", 64'(ddr_rd), 64'd1);
      check("busy_addr_held", 64'(ddr_addr), 64'h600_0040);
    end
    @(posedge clk);
    #1;
    ddr_busy = 1'b0;
    read_byte(28'h200, 8'h03, 20);
    wait_accepts(base_acc + 2, 30);
    repeat (6) @(posedge clk);
    check("busy_accepts", 64'(ddr_accepts - base_acc), 64'd2);
`ifdef WAVE_FETCH_STATS_EN
    check("busy_miss_cnt", 64'(miss_cnt), 64'd2);
`endif

    // Flush while waiting for data: data dropped, then a fresh miss fetch.
    base_acc = ddr_accepts;
    exp_req.push_back(29'h600_0100);
    exp_req.push_back(29'h600_0100);
    exp_req.push_back(29'h600_0101);
    @(posedge clk);
    #1;
    byte_addr = 28'h800;
    wait_accepts(base_acc + 1, 20);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_ready_low", 64'(byte_ready), 64'd0);
    end
    read_byte(28'h800, 8'h09, 30);
    wait_accepts(base_acc + 3, 30);
    repeat (6) @(posedge clk);
    check("flush_accepts", 64'(ddr_accepts - base_acc), 64'd3);
`ifdef WAVE_FETCH_STATS_EN
    check("flush_miss_cnt", 64'(miss_cnt), 64'd1);
`endif

    // Top of address space: prefetch tag wraps to 0.
    base_acc = ddr_accepts;
    exp_req.push_back(29'h7FF_FFFF);
    exp_req.push_back(29'h600_0000);
    read_byte(28'hFFF_FFFF, 8'hFF, 30);
    wait_accepts(base_acc + 2, 30);
    repeat (6) @(posedge clk);
    exp_req.push_back(29'h600_0001);
    read_byte(28'h0, 8'h01, 2);
    wait_accepts(base_acc + 3, 30);
    repeat (6) @(posedge clk);
    check("wrap_accepts", 64'(ddr_accepts - base_acc), 64'd3);

    // Address jump mid-fetch: first fill completes, READY only after the second.
    base_acc = ddr_accepts;
    exp_req.push_back(29'h600_0008);
    exp_req.push_back(29'h600_0200);
    exp_req.push_back(29'h600_0201);
    @(posedge clk);
    #1;
    byte_addr = 28'h40;
    base_fill = ddr_fills;
    wait_accepts(base_acc + 1, 20);
    #1;
    byte_addr = 28'h1000;
    cyc = 0;
    @(negedge clk);
    while (!byte_ready && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!byte_ready) timeout_fail("jump_ready");
    else check("jump_fills_before_ready", 64'(ddr_fills - base_fill), 64'd2);
    read_byte(28'h1000, 8'h11, 2);
    wait_accepts(base_acc + 3, 30);
    repeat (6) @(posedge clk);
    check("jump_accepts", 64'(ddr_accepts - base_acc), 64'd3);

    check("req_queue_drained", 64'(exp_req.size()), 64'd0);
    check("byte_queue_drained", 64'(exp_byte.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
